// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing plus retired-instruction counter.
// Optional build macro ILLEGAL_TRAP_EN: unsupported opcodes trap into HALT instead of retiring as NOPs.
module multicycle_control_fsm #(
    parameter int DWIDTH    = 32,
    parameter int MEM_WAIT  = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DWIDTH-1:0]    irOut,
    input  logic                 comparatorOut,
    output logic                 irEn,
    output logic                 pcEn,
    output logic [1:0]           pcSelect,
    output logic                 regWrite,
    output logic                 aluSrc,
    output logic                 ramRdEn,
    output logic                 ramWrEn,
    output logic                 isByte,
    output logic                 isHalf,
    output logic                 isWord,
    output logic [1:0]           memToReg,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [2:0]           state
);

    // state  | meaning
    // RESET  | idle after reset, all outputs low
    // FETCH  | load instruction register
    // DECODE | register read settles
    // EXEC   | ALU operand select
    // MEM    | data RAM access (loads wait MEM_WAIT cycles)
    // WB     | register write, PC update, retire
    // HALT   | trapped on unsupported opcode, left only by reset
    typedef enum logic [2:0] {
        RESET  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Load wait is a down-counter; MEM ends at terminal count zero.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     stateReg;
    state_t     nextState;
    logic [3:0] waitCnt;

    logic [6:0] opcode;
    logic [1:0] sizeSel;
    logic       isRType, isIAlu, isLoad, isStore, isBranch, isJal, isJalr, isLui, isLegal;
    logic [2:0] sizeBits;
    logic       unusedIrBits;

    assign opcode       = irOut[6:0];
    assign sizeSel      = irOut[13:12];
    assign unusedIrBits = ^{irOut[DWIDTH-1:14], irOut[11:7]};

    assign isRType  = (opcode == OP_RTYPE);
    assign isIAlu   = (opcode == OP_IALU);
    assign isLoad   = (opcode == OP_LOAD);
    assign isStore  = (opcode == OP_STORE);
    assign isBranch = (opcode == OP_BRANCH);
    assign isJal    = (opcode == OP_JAL);
    assign isJalr   = (opcode == OP_JALR);
    assign isLui    = (opcode == OP_LUI);
    assign isLegal  = isRType | isIAlu | isLoad | isStore | isBranch | isJal | isJalr | isLui;

    always_comb begin
        sizeBits = 3'b001;
        case (sizeSel)
            2'b00:   sizeBits = 3'b100;
            2'b01:   sizeBits = 3'b010;
            default: sizeBits = 3'b001;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= RESET;
            waitCnt  <= 4'd0;
            instret  <= '0;
        end else begin
            stateReg <= nextState;
            if (stateReg == EXEC && isLoad)
                waitCnt <= WAIT_LOAD;
            else if (stateReg == MEM && waitCnt != 4'd0)
                waitCnt <= waitCnt - 4'd1;
            if (stateReg == WB)
                instret <= instret + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        nextState = stateReg;
        irEn      = 1'b0;
        pcEn      = 1'b0;
        pcSelect  = 2'b00;
        regWrite  = 1'b0;
        aluSrc    = 1'b0;
        ramRdEn   = 1'b0;
        ramWrEn   = 1'b0;
        isByte    = 1'b0;
        isHalf    = 1'b0;
        isWord    = 1'b0;
        memToReg  = 2'b00;

        case (stateReg)
            RESET:  nextState = FETCH;
            FETCH: begin
                irEn      = 1'b1;
                nextState = DECODE;
            end
            DECODE: nextState = EXEC;
            EXEC: begin
                aluSrc = isIAlu | isLoad | isStore | isJalr;
                if (isLoad || isStore)
                    nextState = MEM;
                else if (isLegal)
                    nextState = WB;
                else
`ifdef ILLEGAL_TRAP_EN
                    nextState = HALT;
`else
                    nextState = WB;
`endif
            end
            MEM: begin
                if (isLoad || isStore)
                    {isByte, isHalf, isWord} = sizeBits;
                ramRdEn = isLoad;
                ramWrEn = isStore;
                if (!(isLoad && waitCnt != 4'd0))
                    nextState = WB;
            end
            WB: begin
                pcEn     = 1'b1;
                regWrite = isRType | isIAlu | isLoad | isJal | isJalr | isLui;
                ramRdEn  = isLoad;
                if (isLoad || isStore)
                    {isByte, isHalf, isWord} = sizeBits;
                if (isLoad)
                    memToReg = 2'b01;
                else if (isJal || isJalr)
                    memToReg = 2'b10;
                else if (isLui)
                    memToReg = 2'b11;
                if (isBranch)
                    pcSelect = comparatorOut ? 2'b01 : 2'b00;
                else if (isJal)
                    pcSelect = 2'b10;
                else if (isJalr)
                    pcSelect = 2'b11;
                nextState = FETCH;
            end
            HALT:    nextState = HALT;
            default: nextState = RESET;
        endcase
    end

    assign state = stateReg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven, scoreboarded bench for multicycle_control_fsm (MEM_WAIT=3, 4-bit instret to exercise wrap).
module tb_multicycle_control_fsm;
    localparam int MEM_WAIT  = 3;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [31:0]          irOut = 32'h0;
    logic                 comparatorOut = 1'b0;
    logic                 irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord;
    logic [1:0]           pcSelect, memToReg;
    logic [CNT_WIDTH-1:0] instret;
    logic [2:0]           state;

    multicycle_control_fsm #(.DWIDTH(32), .MEM_WAIT(MEM_WAIT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset), .irOut(irOut), .comparatorOut(comparatorOut),
        .irEn(irEn), .pcEn(pcEn), .pcSelect(pcSelect), .regWrite(regWrite), .aluSrc(aluSrc),
        .ramRdEn(ramRdEn), .ramWrEn(ramWrEn), .isByte(isByte), .isHalf(isHalf), .isWord(isWord),
        .memToReg(memToReg), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic        cmp;
        int          cycles;
        logic        aluSrc;
        logic        regWrite;
        logic [1:0]  memToReg;
        logic [1:0]  pcSel;
        logic [2:0]  size;
        int          rdCycles;
        int          wrCycles;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int total = 0;
    int bad = 0;
    logic [CNT_WIDTH-1:0] expInstret = '0;

    function automatic vec_t mk(logic [31:0] ir, logic cmp, int cyc, logic alu, logic rw,
                                logic [1:0] m2r, logic [1:0] pcs, logic [2:0] sz, int rd, int wr);
        vec_t v;
        v.ir = ir; v.cmp = cmp; v.cycles = cyc; v.aluSrc = alu; v.regWrite = rw;
        v.memToReg = m2r; v.pcSel = pcs; v.size = sz; v.rdCycles = rd; v.wrCycles = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] allOuts();
        return {irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
                isByte, isHalf, isWord, memToReg};
    endfunction

    // Entered #1 after the edge that made state FETCH; leaves at the same point of the next FETCH.
    task automatic runInstr(input vec_t v);
        vec_t e;
        int cycles = 0, rd = 0, wr = 0, pcCnt = 0, irCnt = 0, rwCnt = 0, clash = 0;
        logic obsAlu = 1'b0, obsRw = 1'b0;
        logic [1:0] obsM2r = 2'b00, obsPc = 2'b00;
        logic [2:0] obsSize = 3'b000;
        irOut = v.ir;
        comparatorOut = v.cmp;
        sb.push_back(v);
        do begin
            @(negedge clk);
            cycles++;
            if (ramRdEn) rd++;
            if (ramWrEn) wr++;
            if (pcEn) pcCnt++;
            if (irEn) irCnt++;
            if (regWrite) rwCnt++;
            if (irEn && (regWrite || ramWrEn || pcEn)) clash++;
            if (state == 3'd3) obsAlu = aluSrc;
            if (state == 3'd5) begin
                obsRw = regWrite; obsM2r = memToReg; obsPc = pcSelect;
                obsSize = {isByte, isHalf, isWord};
            end
        end while (state != 3'd5 && state != 3'd6 && cycles < 40);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            expInstret = expInstret + 1'b1;
            check($sformatf("cycles %h", e.ir), cycles, e.cycles);
            check($sformatf("aluSrc %h", e.ir), obsAlu, e.aluSrc);
            check($sformatf("regWrite %h", e.ir), obsRw, e.regWrite);
            check($sformatf("regWriteCycles %h", e.ir), rwCnt, e.regWrite ? 1 : 0);
            check($sformatf("memToReg %h", e.ir), obsM2r, e.memToReg);
            check($sformatf("pcSelect %h", e.ir), obsPc, e.pcSel);
            check($sformatf("size %h", e.ir), obsSize, e.size);
            check($sformatf("rdCycles %h", e.ir), rd, e.rdCycles);
            check($sformatf("wrCycles %h", e.ir), wr, e.wrCycles);
            check($sformatf("pcEnCycles %h", e.ir), pcCnt, 1);
            check($sformatf("irEnCycles %h", e.ir), irCnt, 1);
            check($sformatf("irEnClash %h", e.ir), clash, 0);
            check($sformatf("instret %h", e.ir), instret, expInstret);
            check($sformatf("backToFetch %h", e.ir), state, 3'd1);
        end
    endtask

    initial begin
        int waitCyc;
        vecs.push_back(mk(32'h00500093, 1'b0, 4, 1'b1, 1'b1, 2'b00, 2'b00, 3'b000, 0, 0)); // ADDI
        vecs.push_back(mk(32'h0000A103, 1'b0, 7, 1'b1, 1'b1, 2'b01, 2'b00, 3'b001, 4, 0)); // LW
        vecs.push_back(mk(32'h0020A223, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 0, 1)); // SW
        vecs.push_back(mk(32'h00000463, 1'b1, 4, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 0, 0)); // BEQ taken
        vecs.push_back(mk(32'h00000463, 1'b0, 4, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 0, 0)); // BEQ not taken
        vecs.push_back(mk(32'h010000EF, 1'b0, 4, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 0, 0)); // JAL
        vecs.push_back(mk(32'h000080E7, 1'b0, 4, 1'b1, 1'b1, 2'b10, 2'b11, 3'b000, 0, 0)); // JALR
        vecs.push_back(mk(32'h000010B7, 1'b0, 4, 1'b0, 1'b1, 2'b11, 2'b00, 3'b000, 0, 0)); // LUI
        vecs.push_back(mk(32'h002081B3, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 3'b000, 0, 0)); // ADD
        vecs.push_back(mk(32'h00008103, 1'b0, 7, 1'b1, 1'b1, 2'b01, 2'b00, 3'b100, 4, 0)); // LB
        vecs.push_back(mk(32'h00209223, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 0, 1)); // SH
        vecs.push_back(mk(32'h0000D103, 1'b0, 7, 1'b1, 1'b1, 2'b01, 2'b00, 3'b010, 4, 0)); // LHU funct3=101
        vecs.push_back(mk(32'h0020B223, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 0, 1)); // store funct3=011

        irOut = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outs", allOuts(), 13'h0);
            check("reset_state", state, 3'd0);
            check("reset_instret", instret, 0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_fetch", state, 3'd1);
        check("first_instret", instret, 0);

        // Two passes over the table; the 4-bit counter wraps through zero on the second.
        for (int pass = 0; pass < 2; pass++)
            for (int i = 0; i < vecs.size(); i++)
                runInstr(vecs[i]);

`ifdef ILLEGAL_TRAP_EN
        irOut = 32'h0000007F;
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (state != 3'd6 && waitCyc < 10);
        check("halt_reached", state, 3'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_state", state, 3'd6);
            check("halt_outs", allOuts(), 13'h0);
            check("halt_instret", instret, expInstret);
        end
`else
        runInstr(mk(32'h0000007F, 1'b0, 4, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 0, 0));
        runInstr(mk(32'h00000097, 1'b0, 4, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 0, 0));
`endif

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expInstret = '0;
        @(posedge clk);
        #1;
        check("recover_fetch", state, 3'd1);

        // Abort a store in MEM: write enable must fall without waiting for a clock.
        irOut = 32'h0020A223;
        waitCyc = 0;
        do begin
            @(negedge clk);
            waitCyc++;
        end while (state != 3'd4 && waitCyc < 10);
        check("abort_in_mem", state, 3'd4);
        check("abort_wr_before", ramWrEn, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_wr_async", ramWrEn, 1'b0);
        check("abort_state_async", state, 3'd0);
        check("abort_instret", instret, 0);
        irOut = 32'h00500093;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_wr_held", ramWrEn, 1'b0);
            check("abort_pc_held", pcEn, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_refetch", state, 3'd1);
        runInstr(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit that drives every control input of the datapath and consumes its instruction-register output (`irOut`) and branch comparator result (`comparatorOut`).
- Sequences each RV32I instruction through FETCH / DECODE / EXEC / MEM / WB.
- Maintains a retired-instruction counter.
- Sits directly upstream of the datapath in the top level.

Parameters:
- DWIDTH, 32, instruction width.
- MEM_WAIT, 1, number of cycles spent in MEM for loads (1..15).
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- irOut  input  DWIDTH  current instruction from the instruction register.
- comparatorOut  input  1  branch condition result from the datapath comparator.
- irEn  output  1  instruction register load enable.
- pcEn  output  1  PC update enable.
- pcSelect  output  2  PC source: 00 = pc+4, 01 = branch target, 10 = JAL target, 11 = JALR target.
- regWrite  output  1  register-file write enable.
- aluSrc  output  1  0 = rs2, 1 = immediate.
- ramRdEn  output  1  data RAM read enable.
- ramWrEn  output  1  data RAM write enable.
- isByte / isHalf / isWord  output  1 each  access size, one-hot.
- memToReg  output  2  writeback source: 00 = ALU, 01 = memory, 10 = PC, 11 = immediate.
- instret  output  CNT_WIDTH  retired-instruction count.
- state  output  3  current state, for debug.

Behaviour:
- State encoding: RESET = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6.
- Reset:
  - reset low forces state = RESET, instret = 0 and the internal MEM wait counter = 0, asynchronously.
  - In RESET every control output is 0.
  - The first rising clk edge with reset high moves to FETCH.
  - Reset asserted mid-instruction aborts immediately; no pending write completes.
- Outputs are decoded from state and irOut (opcode = irOut[6:0], funct3 = irOut[14:12]). Any output not listed for a state is 0.
- FETCH: irEn = 1. Next state DECODE.
- DECODE: all outputs 0 (register read settles). Next state EXEC.
- EXEC:
  - aluSrc = 1 for I-ALU 0010011, LOAD 0000011, STORE 0100011 and JALR 1100111.
  - aluSrc = 0 for R-type 0110011 and BRANCH 1100011.
  - LOAD and STORE go to MEM; every other legal opcode goes to WB.
- MEM:
  - Size decode from funct3[1:0]: 00 → isByte, 01 → isHalf, 10 → isWord, 11 → isWord.
  - The size bits are held in MEM and WB for LOAD and STORE.
  - LOAD: ramRdEn = 1 for MEM_WAIT cycles using a 4-bit counter, then go to WB.
  - STORE: ramWrEn = 1 for exactly one cycle, then go to WB.
- WB:
  - pcEn = 1 for exactly one cycle.
  - regWrite = 1 for R, I-ALU, LOAD, JAL, JALR and LUI; regWrite = 0 for STORE and BRANCH.
  - memToReg: LOAD = 01 (ramRdEn also held at 1); JAL/JALR = 10; LUI 0110111 = 11; all others = 00.
  - pcSelect:
    - BRANCH: 01 if comparatorOut = 1, else 00. comparatorOut is sampled in WB.
    - JAL 1101111: 10.
    - JALR: 11.
    - All others: 00.
  - instret increments by 1 at the end of WB and wraps at 2^CNT_WIDTH to 0.
  - Next state FETCH.
- Cycle counts per instruction:
  - ALU, LUI, branch, jump: 4.
  - Store: 5.
  - Load: 4 + MEM_WAIT.
- Unsupported opcodes (including AUIPC 0010111, SYSTEM and FENCE) are handled as described in Optional Feature.
- regWrite, ramWrEn and pcEn are never asserted in the same cycle as irEn.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode in EXEC goes to HALT.
  - HALT drives all outputs 0, does not increment instret, and is left only by reset.
  - state reads 6.
- Undefined:
  - An unsupported opcode is a NOP: EXEC → WB with regWrite = 0, pcSelect = 00, pcEn = 1.
  - instret increments.

Test Plan:
- Reset low for 3 cycles, then release → all outputs 0 while low; state = 1 (FETCH) after the first edge; instret = 0.
- irOut = 0x00500093 (ADDI x1,x0,5) → states 1, 2, 3, 5; aluSrc = 1 in EXEC; regWrite = 1, memToReg = 00, pcEn = 1, pcSelect = 00 in WB; instret = 1.
- irOut = 0x0000A103 (LW), MEM_WAIT = 3 → ramRdEn = 1 for 3 MEM cycles plus WB; isWord = 1; memToReg = 01; 7 cycles total.
- irOut = 0x0020A223 (SW) → ramWrEn high for exactly 1 cycle; regWrite never high; 5 cycles total.
- irOut = 0x00000463 (BEQ): comparatorOut = 1 → WB pcSelect = 01; comparatorOut = 0 → pcSelect = 00. irOut = 0x010000EF (JAL) → pcSelect = 10, memToReg = 10, regWrite = 1.
- irOut = 0x0000007F (illegal) → HALT (state 6) with instret frozen if ILLEGAL_TRAP_EN is defined; otherwise NOP with instret + 1. Reset pulse in MEM of a store → ramWrEn drops asynchronously and no write pulse follows.
